// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic-computing datapath.
// Used by sng_stream, whose bit ordering is selected by the SNG_SCRAMBLE_EN macro.
package stoch_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } sng_state_e;

  function automatic bit is_pow2_ge2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sng_bitrev.sv
// Combinational W-bit index reversal; turns a linear counter into a van der Corput sequence.
module sng_bitrev
  import stoch_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] idx_i,
  output logic [W-1:0] rev_o
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign rev_o[i] = idx_i[W-1-i];
  end

endmodule

// File: rtl/sng_stream.sv
// Serialises a quota (count of ones) into a BITSTREAM-long unipolar bitstream.
// Define SNG_SCRAMBLE_EN for bit-reversed (van der Corput) ordering; otherwise ones come first.
module sng_stream
  import stoch_pkg::*;
#(
  parameter int BITSTREAM = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(BITSTREAM):0]   quota,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_bit,
  output logic                         out_last
);

  localparam int KW = $clog2(BITSTREAM);
  localparam logic [KW:0]   TVAL  = (KW + 1)'(BITSTREAM);
  localparam logic [KW-1:0] KLAST = KW'(BITSTREAM - 1);

  if (!is_pow2_ge2(BITSTREAM)) begin : g_bad_len
    $error("sng_stream: BITSTREAM must be a power of two and at least 2");
  end

  sng_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW:0]   q_q, q_d;
  logic          out_valid_q, out_bit_q, out_last_q;
  logic          out_valid_d, out_bit_d, out_last_d;
  logic [KW-1:0] sel_d;
  logic [KW:0]   quota_clamped;
  logic          accept;

  assign quota_clamped = (quota > TVAL) ? TVAL : quota;
  assign in_ready = !rst && ((state_q == IDLE) || (out_valid_q && out_last_q && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef SNG_SCRAMBLE_EN
  sng_bitrev #(.W(KW)) u_bitrev (
    .idx_i (k_d),
    .rev_o (sel_d)
  );
`else
  assign sel_d = k_d;
`endif

  // Outputs are computed from next-state k/q so they are registered yet aligned with k.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          q_d     = quota_clamped;
          k_d     = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (!out_last_q) begin
            k_d = k_q + 1'b1;
          end else if (accept) begin
            q_d = quota_clamped;
            k_d = '0;
          end else begin
            k_d     = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == STREAM);
    out_bit_d   = out_valid_d && ({1'b0, sel_d} < q_d);
    out_last_d  = out_valid_d && (k_d == KLAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sng_stream.sv
// Directed self-checking bench for sng_stream at BITSTREAM=8, for either SNG_SCRAMBLE_EN setting.
module tb_sng_stream;

  localparam int T = 8;

  // Expected streams, bit k of each constant is stream bit k.
`ifdef SNG_SCRAMBLE_EN
  localparam logic [7:0] P2 = 8'b0001_0001;
  localparam logic [7:0] P3 = 8'b0001_0101;
  localparam logic [7:0] P5 = 8'b0101_0111;
  localparam logic [7:0] P6 = 8'b0111_0111;
`else
  localparam logic [7:0] P2 = 8'b0000_0011;
  localparam logic [7:0] P3 = 8'b0000_0111;
  localparam logic [7:0] P5 = 8'b0001_1111;
  localparam logic [7:0] P6 = 8'b0011_1111;
`endif
  localparam logic [7:0] P0 = 8'b0000_0000;
  localparam logic [7:0] P8 = 8'b1111_1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] quota;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;

  int checks = 0;
  int errors = 0;
  int ones;

  sng_stream #(.BITSTREAM(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quota     (quota),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] qt, input logic ordy);
    in_valid  = v;
    quota     = qt;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consume a full stream with out_ready high, then confirm the return to IDLE.
  task automatic streamCheck(input string tag, input logic [7:0] exp);
    for (int k = 0; k < T; k++) begin
      checkOutput({tag, " valid"}, 8'(out_valid), 8'd1);
      checkOutput({tag, " bit"}, 8'(out_bit), 8'(exp[k]));
      checkOutput({tag, " last"}, 8'(out_last), 8'(k == T - 1));
      tick();
    end
    checkOutput({tag, " idle valid"}, 8'(out_valid), 8'd0);
    checkOutput({tag, " idle ready"}, 8'(in_ready), 8'd1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 4'd3, 1'b1);

    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst valid", 8'(out_valid), 8'd0);
      checkOutput("rst bit", 8'(out_bit), 8'd0);
      checkOutput("rst last", 8'(out_last), 8'd0);
      checkOutput("rst ready", 8'(in_ready), 8'd0);
    end
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("post-rst ready", 8'(in_ready), 8'd1);
    checkOutput("post-rst valid", 8'(out_valid), 8'd0);

    applyStimulus(1'b1, 4'd3, 1'b1);
    checkOutput("accept-cycle valid", 8'(out_valid), 8'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1);
    streamCheck("q3", P3);

    applyStimulus(1'b1, 4'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd7, 1'b1);
    streamCheck("q0", P0);

    applyStimulus(1'b1, 4'd8, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1);
    streamCheck("q8", P8);

    applyStimulus(1'b1, 4'd12, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd1, 1'b1);
    streamCheck("q12 clamp", P8);

    // Quota toggles while in_valid is low and again mid-stream; capture must not move.
    applyStimulus(1'b1, 4'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd8, 1'b1);
    tick();
    quota = 4'd0;
    for (int k = 1; k < T; k++) begin
      checkOutput("late quota bit", 8'(out_bit), 8'(P2[k]));
      tick();
    end
    checkOutput("late quota end", 8'(out_valid), 8'd0);

    // Backpressure on beat 2 for three cycles.
    applyStimulus(1'b1, 4'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1);
    ones = 0;
    for (int k = 0; k < T; k++) begin
      if (k == 2) begin
        for (int s = 0; s < 3; s++) begin
          applyStimulus(1'b0, 4'd0, 1'b0);
          checkOutput("stall bit", 8'(out_bit), 8'(P5[2]));
          checkOutput("stall last", 8'(out_last), 8'd0);
          checkOutput("stall valid", 8'(out_valid), 8'd1);
          tick();
        end
        applyStimulus(1'b0, 4'd0, 1'b1);
      end
      checkOutput("bp bit", 8'(out_bit), 8'(P5[k]));
      checkOutput("bp last", 8'(out_last), 8'(k == T - 1));
      if (out_bit === 1'b1) ones++;
      tick();
    end
    checkOutput("bp ones", 8'(ones), 8'd5);
    checkOutput("bp end", 8'(out_valid), 8'd0);

    // Back-to-back: quota 2 waits on the last beat of the quota 6 stream.
    applyStimulus(1'b1, 4'd6, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd2, 1'b1);
    for (int k = 0; k < T; k++) begin
      checkOutput("b2b bit", 8'(out_bit), 8'(P6[k]));
      checkOutput("b2b ready", 8'(in_ready), 8'(k == T - 1));
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b1);
    streamCheck("b2b q2", P2);

    // Reset lands on beat 4; a fresh quota must start again from index 0.
    applyStimulus(1'b1, 4'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("pre-rst bit", 8'(out_bit), 8'(P5[k]));
      tick();
    end
    rst = 1'b1;
    tick();
    checkOutput("mid-rst valid", 8'(out_valid), 8'd0);
    checkOutput("mid-rst last", 8'(out_last), 8'd0);
    checkOutput("mid-rst ready", 8'(in_ready), 8'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'd3, 1'b1);
    checkOutput("restart ready", 8'(in_ready), 8'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1);
    streamCheck("restart q3", P3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
